// File: rtl/fp_to_int_seq_pkg.sv
// Shared definitions for the short-float to integer converter.
// The package is named fp_pkg because the floating_point adder imports it too.
// Contents: default format widths, exponent bias, output width and the
// converter FSM state encoding.
package fp_pkg;
   localparam int FP_FRAC_W   = 8;
   localparam int FP_EXP_W    = 4;
   localparam int FP_EXP_BIAS = 4;
   localparam int FP_INT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FIN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/fp_to_int_seq_if.sv
// Operand/result bus of fp_to_int_seq.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds its payload stable from raising valid until that edge,
// and ready may depend combinationally on internal state only.
//   master: upstream operand source and downstream result consumer (bench)
//   slave : the converter
//   in_valid/in_ready, sign_in, frac_in, exp_in   operand side
//   out_valid/out_ready, int_out, ovf              result side
interface fp_to_int_seq_if #(
   parameter int FRAC_W = 8,
   parameter int EXP_W  = 4,
   parameter int INT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic              sign_in;
   logic [FRAC_W-1:0] frac_in;
   logic [EXP_W-1:0]  exp_in;
   logic              out_valid;
   logic              out_ready;
   logic [INT_W-1:0]  int_out;
   logic              ovf;

   modport master (
      output in_valid, sign_in, frac_in, exp_in, out_ready,
      input  in_ready, out_valid, int_out, ovf
   );

   modport slave (
      input  in_valid, sign_in, frac_in, exp_in, out_ready,
      output in_ready, out_valid, int_out, ovf
   );
endinterface

// File: rtl/fp_to_int_seq_finalize.sv
// fp_int_finalize: combinational final stage of the converter.
// Optional rounding, range check, saturation and negation of the magnitude.
// Build option: FP_ROUND_NEAREST_EN selects round-half-to-even, otherwise the
// shifted-out bits are dropped (truncation toward zero).
//   mag_i    unsigned magnitude after shifting
//   guard_i  last bit shifted out on a right shift
//   sticky_i OR of all bits shifted out below the guard
//   sign_i   operand sign
//   ovf_i    magnitude overflowed during a left shift
//   int_o    two's complement result
//   ovf_o    result saturated
module fp_int_finalize #(
   parameter int INT_W = 16
) (
   input  logic [INT_W-1:0] mag_i,
   input  logic             guard_i,
   input  logic             sticky_i,
   input  logic             sign_i,
   input  logic             ovf_i,
   output logic [INT_W-1:0] int_o,
   output logic             ovf_o
);
   localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

   logic [INT_W-1:0] mag_r;

`ifdef FP_ROUND_NEAREST_EN
   logic inc;
   // A right shift leaves mag below 2^FRAC_W, so this add cannot wrap.
   assign inc   = guard_i & (sticky_i | mag_i[0]);
   assign mag_r = mag_i + {{(INT_W-1){1'b0}}, inc};
`else
   logic unused_rnd;
   assign unused_rnd = guard_i ^ sticky_i;
   assign mag_r      = mag_i;
`endif

   always_comb begin
      int_o = '0;
      ovf_o = 1'b0;
      if (!sign_i && (ovf_i || mag_r > MAX_POS)) begin
         int_o = MAX_POS;
         ovf_o = 1'b1;
      end else if (sign_i && (ovf_i || mag_r > MIN_NEG)) begin
         int_o = MIN_NEG;
         ovf_o = 1'b1;
      end else begin
         // A magnitude of exactly 2^(INT_W-1) negates onto MIN_NEG.
         int_o = sign_i ? ('0 - mag_r) : mag_r;
      end
   end
endmodule

// File: rtl/fp_to_int_seq.sv
// fp_to_int_seq: sequential converter from {sign, frac, exp} short floats to
// a signed INT_W integer, value = (-1)^sign * frac * 2^(exp-EXP_BIAS).
// The magnitude is shifted one bit per clock; one conversion at a time.
// Build option: FP_ROUND_NEAREST_EN (round half to even in the final stage).
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, aborts any conversion
//   bus      fp_to_int_seq_if.slave operand/result handshakes
//   state_o  current FSM state, for observation
module fp_to_int_seq
   import fp_pkg::*;
#(
   parameter int FRAC_W   = FP_FRAC_W,
   parameter int EXP_W    = FP_EXP_W,
   parameter int EXP_BIAS = FP_EXP_BIAS,
   parameter int INT_W    = FP_INT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fp_to_int_seq_if.slave         bus,
   output state_e                 state_o
);
   localparam int CW = EXP_W + 2;
   localparam logic signed [CW-1:0] BIAS_S  = CW'(EXP_BIAS);
   localparam logic [CW-1:0]        CNT_ONE = CW'(1);

   state_e           state_q;
   logic             sign_q;
   logic [INT_W-1:0] mag_q;
   logic [CW-1:0]    cnt_q;
   logic             left_q;
   logic             guard_q;
   logic             sticky_q;
   logic             ovf_q;
   logic [INT_W-1:0] int_q;
   logic             out_valid_q;

   logic signed [CW-1:0] d_w;
   logic                 d_neg;
   logic [CW-1:0]        d_abs;
   logic [INT_W-1:0]     int_d;
   logic                 ovf_d;

   // Two extra bits keep exp - bias exact and signed for any exponent.
   assign d_w   = $signed({2'b00, bus.exp_in}) - BIAS_S;
   assign d_neg = d_w[CW-1];
   assign d_abs = d_neg ? $unsigned(-d_w) : $unsigned(d_w);

   fp_int_finalize #(.INT_W(INT_W)) u_fin (
      .mag_i    (mag_q),
      .guard_i  (guard_q),
      .sticky_i (sticky_q),
      .sign_i   (sign_q),
      .ovf_i    (ovf_q),
      .int_o    (int_d),
      .ovf_o    (ovf_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         cnt_q       <= '0;
         left_q      <= 1'b0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         ovf_q       <= 1'b0;
         int_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sign_q   <= bus.sign_in;
                  mag_q    <= {{(INT_W-FRAC_W){1'b0}}, bus.frac_in};
                  cnt_q    <= d_abs;
                  left_q   <= ~d_neg;
                  guard_q  <= 1'b0;
                  sticky_q <= 1'b0;
                  ovf_q    <= 1'b0;
                  state_q  <= (d_abs == '0) ? ST_FIN : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (left_q) begin
                  // A set MSB would be lost by this shift: saturate now.
                  if (mag_q[INT_W-1]) begin
                     ovf_q   <= 1'b1;
                     state_q <= ST_FIN;
                  end else begin
                     mag_q <= mag_q << 1;
                     cnt_q <= cnt_q - CNT_ONE;
                     if (cnt_q == CNT_ONE) state_q <= ST_FIN;
                  end
               end else begin
                  mag_q    <= mag_q >> 1;
                  guard_q  <= mag_q[0];
                  sticky_q <= sticky_q | guard_q;
                  cnt_q    <= cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               int_q       <= int_d;
               ovf_q       <= ovf_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.int_out   = int_q;
   assign bus.ovf       = ovf_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq (INT_W=16, EXP_BIAS=4). Expected results come from
// an arithmetic model and are queued when an operand is accepted.
module tb_fp_to_int_seq;
   import fp_pkg::*;

   localparam int INT_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_to_int_seq_if #(.FRAC_W(8), .EXP_W(4), .INT_W(INT_W)) bus ();
   state_e state_o;

   fp_to_int_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (state_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [INT_W:0] exp_q[$];  // {ovf, int_out}

`ifdef FP_ROUND_NEAREST_EN
   localparam int RND_1P5 = 2;
`else
   localparam int RND_1P5 = 1;
`endif

   // Exact value of the operand, rounded per build, then clipped to INT_W.
   function automatic logic [INT_W:0] model(input logic s, input logic [7:0] f,
                                            input logic [3:0] e);
      longint q;
      longint v;
      int     d;
`ifdef FP_ROUND_NEAREST_EN
      longint rem;
      longint half;
`endif
      d = int'(e) - 4;
      if (d >= 0) begin
         q = longint'(f) << d;
      end else begin
         q = longint'(f) >> (-d);
`ifdef FP_ROUND_NEAREST_EN
         rem  = longint'(f) - (q << (-d));
         half = longint'(1) << (-d - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      end
      v = s ? -q : q;
      if (v > 32767) return {1'b1, 16'h7FFF};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, v[15:0]};
   endfunction

   // Present an operand until it is accepted; queue its expected result.
   task automatic drive_op(input logic s, input logic [7:0] f, input logic [3:0] e,
                           output bit ok, output time t_cap);
      ok    = 1'b0;
      t_cap = 0;
      bus.in_valid = 1'b1;
      bus.sign_in  = s;
      bus.frac_in  = f;
      bus.exp_in   = e;
      for (int i = 0; i < 100; i++) begin
         if (bus.in_ready) begin
            @(posedge clk);
            t_cap = $time;
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (ok) exp_q.push_back(model(s, f, e));
   endtask

   // Wait for out_valid; lat counts edges since the capture edge.
   task automatic wait_result(output logic [INT_W-1:0] r, output logic o,
                              output int lat, output bit ok);
      ok  = 1'b0;
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      r = bus.int_out;
      o = bus.ovf;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.sign_in   = 1'b0;
      bus.frac_in   = '0;
      bus.exp_in    = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.int_out !== '0) $display("FAIL reset_int_out: got %0d want 0", bus.int_out);
      else n_pass++;
      n_checks++;
      if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf);
      else n_pass++;
      n_checks++;
      if (state_o !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_directed();
      logic           s_v[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0]     f_v[7] = '{8'h8F, 8'd52, 8'd0, 8'd3, 8'd5, 8'h80, 8'h80};
      logic [3:0]     e_v[7] = '{4'd4, 4'd5, 4'd0, 4'd3, 4'd3, 4'd12, 4'd12};
      int             i_v[7] = '{143, -104, 0, RND_1P5, 2, -32768, 32767};
      logic           o_v[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [INT_W-1:0] r;
      logic           o;
      int             lat;
      bit             ok;
      time            t;
      logic [INT_W:0] e;
      for (int k = 0; k < 7; k++) begin
         drive_op(s_v[k], f_v[k], e_v[k], ok, t);
         wait_result(r, o, lat, ok);
         n_checks++;
         if (!ok) $display("FAIL dir%0d_timeout: got no out_valid want out_valid", k);
         else n_pass++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (r !== e[INT_W-1:0]) $display("FAIL dir%0d_sb_int: got %0d want %0d", k, $signed(r), $signed(e[INT_W-1:0]));
         else n_pass++;
         n_checks++;
         if (int'($signed(r)) != i_v[k] || o !== o_v[k])
            $display("FAIL dir%0d_const: got %0d/%b want %0d/%b", k, $signed(r), o, i_v[k], o_v[k]);
         else n_pass++;
         n_checks++;
         if (o !== e[INT_W]) $display("FAIL dir%0d_sb_ovf: got %b want %b", k, o, e[INT_W]);
         else n_pass++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_latency();
      logic [7:0] f_v[3]   = '{8'h8F, 8'd1, 8'd12};
      logic [3:0] e_v[3]   = '{4'd4, 4'd7, 4'd2};
      int         lat_v[3] = '{1, 4, 3};
      logic [INT_W-1:0] r;
      logic       o;
      int         lat;
      bit         ok;
      time        t0, t1;
      logic [INT_W:0] e;
      for (int k = 0; k < 3; k++) begin
         drive_op(1'b0, f_v[k], e_v[k], ok, t0);
         n_checks++;
         if (bus.out_valid !== 1'b0) $display("FAIL lat%0d_early_valid: got %b want 0", k, bus.out_valid);
         else n_pass++;
         wait_result(r, o, lat, ok);
         n_checks++;
         if (lat != lat_v[k]) $display("FAIL lat%0d_cycles: got %0d want %0d", k, lat, lat_v[k]);
         else n_pass++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if ({o, r} !== e) $display("FAIL lat%0d_result: got %0d want %0d", k, $signed(r), $signed(e[INT_W-1:0]));
         else n_pass++;
         @(posedge clk);
         #1;
         // The next operand is taken straight away: spacing is |d|+3 edges.
         drive_op(1'b0, 8'd7, 4'd4, ok, t1);
         n_checks++;
         if ((t1 - t0) / 10 != time'(lat_v[k] + 2))
            $display("FAIL lat%0d_throughput: got %0d want %0d", k, (t1 - t0) / 10, lat_v[k] + 2);
         else n_pass++;
         wait_result(r, o, lat, ok);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if ({o, r} !== e) $display("FAIL lat%0d_next: got %0d want %0d", k, $signed(r), $signed(e[INT_W-1:0]));
         else n_pass++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_early_exit();
      logic [INT_W-1:0] r;
      logic o;
      int   lat;
      bit   ok;
      time  t;
      logic [INT_W:0] e;
      drive_op(1'b0, 8'hFF, 4'd15, ok, t);
      wait_result(r, o, lat, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (r !== 16'h7FFF || o !== 1'b1 || {o, r} !== e)
         $display("FAIL early_result: got %0d/%b want 32767/1", $signed(r), o);
      else n_pass++;
      n_checks++;
      if (!ok || lat >= 12) $display("FAIL early_latency: got %0d want below 12", lat);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [INT_W-1:0] r;
      logic o;
      int   lat;
      bit   ok;
      time  t;
      logic [INT_W:0] e;
      bus.out_ready = 1'b0;
      drive_op(1'b0, 8'h8F, 4'd4, ok, t);
      wait_result(r, o, lat, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({o, r} !== e) $display("FAIL bp_result: got %0d want %0d", $signed(r), $signed(e[INT_W-1:0]));
      else n_pass++;
      // A competing operand during the stall must be ignored.
      bus.in_valid = 1'b1;
      bus.sign_in  = 1'b1;
      bus.frac_in  = 8'd52;
      bus.exp_in   = 4'd5;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.int_out !== e[INT_W-1:0] || bus.ovf !== e[INT_W])
            $display("FAIL bp_stable%0d: got %b/%0d/%b want 1/%0d/%b", c, bus.out_valid,
                     $signed(bus.int_out), bus.ovf, $signed(e[INT_W-1:0]), e[INT_W]);
         else n_pass++;
         n_checks++;
         if (bus.in_ready !== 1'b0 || state_o !== ST_DONE)
            $display("FAIL bp_busy%0d: got ready %b state %0d want ready 0 state %0d", c, bus.in_ready, state_o, ST_DONE);
         else n_pass++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || state_o !== ST_IDLE)
         $display("FAIL bp_release: got valid %b state %0d want valid 0 state %0d", bus.out_valid, state_o, ST_IDLE);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [INT_W-1:0] r;
      logic o;
      int   lat;
      bit   ok;
      time  t;
      logic [INT_W:0] e;
      drive_op(1'b0, 8'd1, 4'd15, ok, t);
      exp_q.delete();  // this conversion is aborted by reset
      @(posedge clk);
      #1;
      n_checks++;
      if (state_o !== ST_SHIFT) $display("FAIL mid_in_shift: got %0d want %0d", state_o, ST_SHIFT);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.int_out !== '0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b0 || state_o !== ST_IDLE)
         $display("FAIL mid_reset: got %0d/%b/%b state %0d want 0/0/0 state %0d",
                  bus.int_out, bus.ovf, bus.out_valid, state_o, ST_IDLE);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive_op(1'b1, 8'd52, 4'd5, ok, t);
      wait_result(r, o, lat, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if ({o, r} !== e || int'($signed(r)) != -104)
         $display("FAIL mid_next: got %0d/%b want -104/0", $signed(r), o);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [INT_W-1:0] r;
      logic o;
      int   lat;
      int   stall;
      bit   ok;
      time  t;
      logic [INT_W:0] e;
      for (int k = 0; k < 40; k++) begin
         drive_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), ok, t);
         stall = $urandom_range(0, 3);
         bus.out_ready = (stall == 0);
         wait_result(r, o, lat, ok);
         repeat (stall) begin
            @(posedge clk);
            #1;
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         n_checks++;
         if (!ok || bus.out_valid !== 1'b1 || {bus.ovf, bus.int_out} !== e)
            $display("FAIL rnd%0d: got %0d/%b want %0d/%b (f=%0d e=%0d s=%b)", k,
                     $signed(bus.int_out), bus.ovf, $signed(e[INT_W-1:0]), e[INT_W],
                     bus.frac_in, bus.exp_in, bus.sign_in);
         else n_pass++;
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_latency();
      test_early_exit();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
